// File: rtl/siso_ctrl_pkg.sv
// Shared definitions for the SISO shift controller.
// Holds the FSM state encoding and the default word/chain dimensions.
package siso_ctrl_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultDepth = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_chain.sv
// Serial chain of DEPTH D flip-flops, shifting on every rising clock edge.
// Ports:
//   clk - clock
//   rst - asynchronous active-low reset, clears every stage
//   D   - serial input into stage 1
//   Q   - output of stage DEPTH
module shift_chain #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic D,
  output logic Q
);

  logic [DEPTH-1:0] stages_q, stages_d;

  always_comb begin
    stages_d    = stages_q;
    stages_d[0] = D;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stages_d[i] = stages_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stages_q <= '0;
    end else begin
      stages_q <= stages_d;
    end
  end

  assign Q = stages_q[DEPTH-1];

endmodule

// File: rtl/siso_shift_controller.sv
// Serializes a parallel word LSB first through a DEPTH-stage flip-flop chain and
// reassembles it from the chain output, presenting it with a valid/ready handshake.
// Ports:
//   clk, rst             - clock, asynchronous active-low reset
//   in_valid/in_ready    - parallel word handshake, in_data is the word to send
//   out_valid/out_ready  - recovered word handshake, out_data is the recovered word
//   busy                 - transfer in progress (SHIFT or DONE)
//   ser_d                - bit currently driven into chain stage 1
module siso_shift_controller
  import siso_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             ser_d
);

  localparam int unsigned Total = WIDTH + DEPTH;
  localparam int unsigned CntW  = $clog2(Total);
  localparam logic [CntW-1:0] LastCnt  = CntW'(Total - 1);
  localparam logic [CntW-1:0] WidthCnt = CntW'(WIDTH);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] tx_shift;
  logic             chain_q;

  shift_chain #(
    .DEPTH(DEPTH)
  ) u_chain (
    .clk(clk),
    .rst(rst),
    .D  (ser_d),
    .Q  (chain_q)
  );

  // Once cnt passes WIDTH the chain is fed zeros, flushing it by the time DONE is reached.
  assign tx_shift = tx_q >> cnt_q;
  assign ser_d    = (state_q == StShift) && (cnt_q < WidthCnt) ? tx_shift[0] : 1'b0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          tx_d    = in_data;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // Bit fed at cycle c reaches the chain output at cycle c + DEPTH.
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (cnt_q == CntW'(i + DEPTH)) begin
            rx_d[i] = chain_q;
          end
        end
        // Hold at the last count rather than increment, so cnt never wraps.
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_data  = rx_q;

endmodule

// File: doc/siso_shift_controller.md
SISO_SHIFT_CONTROLLER -- requirements
Module: siso_shift_controller

Interface
REQ-001 Parameter WIDTH, default 8: bits per transferred word.
REQ-002 Parameter DEPTH, default 4: number of D flip-flop stages in the serial chain.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 in_valid  input  1  parallel word offered.
REQ-006 in_data  input  WIDTH  word to serialize.
REQ-007 in_ready  output  1  controller can accept a word.
REQ-008 out_valid  output  1  recovered word available.
REQ-009 out_data  output  WIDTH  word recovered from the chain output.
REQ-010 out_ready  input  1  consumer accepts out_data.
REQ-011 busy  output  1  transfer in progress (SHIFT or DONE).
REQ-012 ser_d  output  1  bit currently driven into chain stage 1, for observation.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-014 in_ready SHALL equal (state == IDLE); acceptance is in_valid & in_ready at a rising edge.
REQ-015 On acceptance: latch in_data into the TX register, clear counter cnt to 0, and go to SHIFT.
REQ-016 In SHIFT, ser_d SHALL be TX[cnt] (LSB first) while cnt < WIDTH, and 0 otherwise.
REQ-017 In IDLE and DONE, ser_d SHALL be 0.
REQ-018 The chain SHALL shift on every clock with no enable; Q of stage DEPTH in cycle cnt carries the bit fed at cnt-DEPTH.
REQ-019 In SHIFT, when cnt >= DEPTH, the controller SHALL capture chain Q into RX[cnt-DEPTH].
REQ-020 cnt SHALL increment by 1 per SHIFT cycle; it is sized ceil(log2(WIDTH+DEPTH)) bits and never wraps.
REQ-021 On the SHIFT cycle with cnt = WIDTH+DEPTH-1 the FSM SHALL go to DONE.
REQ-022 In DONE: out_valid = 1 and out_data = RX, both held stable until out_valid & out_ready.
REQ-023 On out_valid & out_ready the FSM SHALL return to IDLE; out_valid falls on that edge.
REQ-024 Latency: out_valid SHALL rise exactly WIDTH+DEPTH rising edges after the acceptance edge (12 at defaults).
REQ-025 At DONE the chain SHALL hold all zeros, because DEPTH trailing zeros are shifted in after the last data bit.
REQ-026 in_valid while busy SHALL be ignored; no word is latched.
REQ-027 out_ready outside DONE SHALL have no effect.
REQ-028 A new word SHALL NOT be accepted in the same cycle as the DONE handshake; the earliest acceptance is the next cycle (in IDLE).
REQ-029 out_data SHALL retain its last value in IDLE.

Reset
REQ-030 While rst = 0, regardless of clk:
- state = IDLE
- cnt = 0
- TX = 0 and RX = 0
- every chain stage = 0
- outputs: out_valid = 0, out_data = 0, busy = 0, ser_d = 0, in_ready = 1
REQ-031 Reset asserted mid-transfer SHALL abort the transfer with no out_valid pulse.
REQ-032 The first edge after reset release SHALL behave as IDLE.

Structure
REQ-033 Shared package siso_ctrl_pkg SHALL hold the state encoding typedef and the default WIDTH/DEPTH constants.
REQ-034 The chain SHALL be one sub-module, shift_chain: DEPTH async-active-low-reset D flip-flops with ports clk, rst, D, Q.
REQ-035 The controller SHALL contain only the FSM, counter, TX and RX registers.

Verification
REQ-036 Reset: hold rst = 0 for 3 cycles with in_valid = 1 -> out_valid = 0, busy = 0, ser_d = 0, in_ready = 1; nothing is accepted.
REQ-037 Single transfer of 0xA5, out_ready = 1:
- ser_d sequence over cnt 0..7 = 1,0,1,0,0,1,0,1
- out_valid rises 12 edges after acceptance with out_data = 0xA5
- out_valid lasts one cycle
REQ-038 Backpressure on 0x3C, out_ready = 0 for 5 cycles -> out_valid and out_data = 0x3C held, in_ready = 0; handshake on the 6th cycle, then IDLE.
REQ-039 Back-to-back 0xFF then 0x00 with in_valid held high:
- second word accepted the cycle after the first DONE handshake
- outputs 0xFF then 0x00
- nothing accepted while busy
REQ-040 Abort and recover:
- rst pulsed low at cnt = 5 of 0x81 -> no out_valid, chain cleared
- next transfer of 0x81 -> out_data = 0x81
REQ-041 Parameter sweep WIDTH=1/DEPTH=1 and WIDTH=16/DEPTH=4 with random words -> out_data == in_data; latency WIDTH+DEPTH each time.
